// File: rtl/verificador_hash_if.sv
// Handshake bundle between the nonce generator / hash core side and the hash checker.
interface verificador_hash_if;
  logic        inicio;
  logic [31:0] nonce;
  logic [31:0] hash_in;
  logic [31:0] objetivo;
  logic        alimentar;
  logic        terminado;
  logic        encontrado;
  logic        agotado;
  logic [31:0] nonce_ganador;
  logic [31:0] hash_ganador;
  logic [31:0] intentos;

  modport master (
    output inicio, nonce, hash_in, objetivo,
    input  alimentar, terminado, encontrado, agotado, nonce_ganador, hash_ganador, intentos
  );

  modport slave (
    input  inicio, nonce, hash_in, objetivo,
    output alimentar, terminado, encontrado, agotado, nonce_ganador, hash_ganador, intentos
  );
endinterface

// File: rtl/verificador_hash.sv
// Realigns returned hashes with their nonces through a LATENCIA-deep delay line and
// checks each against the difficulty target, latching the first win or budget exhaustion.
module verificador_hash #(
  parameter int unsigned LATENCIA     = 4,
  parameter int unsigned MAX_INTENTOS = 1000
) (
  input logic               clk,
  input logic               reset,
  verificador_hash_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StBuscando, StEncontrado, StAgotado} estado_e;

  localparam int unsigned Ultima = LATENCIA - 1;

  estado_e estado_q, estado_d;

  logic [31:0]         linea_nonce_q [LATENCIA];
  logic [31:0]         linea_nonce_d [LATENCIA];
  logic [LATENCIA-1:0] linea_valid_q, linea_valid_d;

  logic        terminado_q, terminado_d;
  logic        encontrado_q, encontrado_d;
  logic        agotado_q, agotado_d;
  logic [31:0] nonce_ganador_q, nonce_ganador_d;
  logic [31:0] hash_ganador_q, hash_ganador_d;
  logic [31:0] intentos_q, intentos_d;

  logic en_busqueda;
  logic hay_salida;
  logic gana;
  logic limite;
  logic vaciar;

  assign en_busqueda = (estado_q == StBuscando);
  assign hay_salida  = linea_valid_q[Ultima];
  assign gana        = (bus.hash_in < bus.objetivo);
  assign limite      = ((intentos_q + 32'd1) == MAX_INTENTOS);

  always_comb begin
    estado_d        = estado_q;
    terminado_d     = terminado_q;
    encontrado_d    = encontrado_q;
    agotado_d       = agotado_q;
    nonce_ganador_d = nonce_ganador_q;
    hash_ganador_d  = hash_ganador_q;
    intentos_d      = intentos_q;
    vaciar          = 1'b0;

    linea_nonce_d[0] = en_busqueda ? bus.nonce : 32'd0;
    linea_valid_d[0] = en_busqueda;
    for (int unsigned i = 1; i < LATENCIA; i++) begin
      linea_nonce_d[i] = linea_nonce_q[i-1];
      linea_valid_d[i] = linea_valid_q[i-1];
    end

    unique case (estado_q)
      StIdle: begin
        if (bus.inicio) begin
          estado_d        = StBuscando;
          terminado_d     = 1'b0;
          encontrado_d    = 1'b0;
          agotado_d       = 1'b0;
          nonce_ganador_d = 32'd0;
          hash_ganador_d  = 32'd0;
          intentos_d      = 32'd0;
          vaciar          = 1'b1;
        end
      end
      StBuscando: begin
        if (!bus.inicio) begin
          estado_d    = StIdle;
          terminado_d = 1'b0;
          vaciar      = 1'b1;
        end else if (hay_salida) begin
          intentos_d = intentos_q + 32'd1;
          // A win on the final attempt beats exhaustion.
          if (gana) begin
            estado_d        = StEncontrado;
            nonce_ganador_d = linea_nonce_q[Ultima];
            hash_ganador_d  = bus.hash_in;
            encontrado_d    = 1'b1;
            terminado_d     = 1'b1;
            vaciar          = 1'b1;
          end else if (limite) begin
            estado_d    = StAgotado;
            agotado_d   = 1'b1;
            terminado_d = 1'b1;
            vaciar      = 1'b1;
          end
        end
      end
      StEncontrado, StAgotado: begin
        if (!bus.inicio) begin
          estado_d    = StIdle;
          terminado_d = 1'b0;
        end
      end
      default: estado_d = StIdle;
    endcase

    if (vaciar) begin
      for (int unsigned i = 0; i < LATENCIA; i++) begin
        linea_nonce_d[i] = 32'd0;
      end
      linea_valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      estado_q        <= StIdle;
      terminado_q     <= 1'b0;
      encontrado_q    <= 1'b0;
      agotado_q       <= 1'b0;
      nonce_ganador_q <= 32'd0;
      hash_ganador_q  <= 32'd0;
      intentos_q      <= 32'd0;
      linea_valid_q   <= '0;
      for (int unsigned i = 0; i < LATENCIA; i++) begin
        linea_nonce_q[i] <= 32'd0;
      end
    end else begin
      estado_q        <= estado_d;
      terminado_q     <= terminado_d;
      encontrado_q    <= encontrado_d;
      agotado_q       <= agotado_d;
      nonce_ganador_q <= nonce_ganador_d;
      hash_ganador_q  <= hash_ganador_d;
      intentos_q      <= intentos_d;
      linea_valid_q   <= linea_valid_d;
      for (int unsigned i = 0; i < LATENCIA; i++) begin
        linea_nonce_q[i] <= linea_nonce_d[i];
      end
    end
  end

  assign bus.alimentar     = en_busqueda;
  assign bus.terminado     = terminado_q;
  assign bus.encontrado    = encontrado_q;
  assign bus.agotado       = agotado_q;
  assign bus.nonce_ganador = nonce_ganador_q;
  assign bus.hash_ganador  = hash_ganador_q;
  assign bus.intentos      = intentos_q;

endmodule
